// File: rtl/oser10_lane_ctrl.sv
// Per-lane bring-up sequencer and word feeder for one 10:1 output serializer lane.
// Walks IDLE -> RESET -> SETTLE -> TRAIN -> RUN and aborts to IDLE whenever enable or lock drops.
module oser10_lane_ctrl #(
    parameter int          RST_CYCLES    = 8,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          TRAIN_WORDS   = 64,
    parameter logic [9:0]  TRAIN_PAT     = 10'h354,
    parameter logic [9:0]  IDLE_WORD     = 10'h0AB
) (
    input  logic        clk_par,
    input  logic        srst,
    input  logic        enable,
    input  logic        pll_locked,
    input  logic        src_valid,
    input  logic [9:0]  src_data,
    output logic        src_ready,
    output logic        ser_rst,
    output logic [9:0]  ser_d,
    output logic        link_up,
    output logic [15:0] underrun_cnt,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    localparam logic [15:0] RST_LD    = 16'(RST_CYCLES);
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);
    localparam logic [15:0] TRAIN_LD  = 16'(TRAIN_WORDS);

    state_t      state;
    logic [15:0] cnt;
    logic        lock_m;
    logic        lock_s;
    logic        go;
    logic        accept;

    assign go        = enable & lock_s;
    assign src_ready = (state == ST_RUN) & go;
    assign accept    = src_ready & src_valid;
    assign state_o   = state;

    // Outputs follow the state held during the cycle, so each phase shows up one edge after entry.
    always_ff @(posedge clk_par) begin
        if (srst) begin
            state        <= ST_IDLE;
            cnt          <= 16'd0;
            lock_m       <= 1'b0;
            lock_s       <= 1'b0;
            ser_rst      <= 1'b1;
            ser_d        <= IDLE_WORD;
            link_up      <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            if (state != ST_IDLE && !go) begin
                // Abort: back to IDLE with the serializer held in reset on this same edge.
                state   <= ST_IDLE;
                ser_rst <= 1'b1;
                ser_d   <= IDLE_WORD;
                link_up <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ser_rst <= 1'b1;
                        ser_d   <= IDLE_WORD;
                        link_up <= 1'b0;
                        if (go) begin
                            state <= ST_RESET;
                            cnt   <= RST_LD;
                        end
                    end
                    ST_RESET: begin
                        ser_rst <= 1'b1;
                        ser_d   <= IDLE_WORD;
                        link_up <= 1'b0;
                        if (cnt <= 16'd1) begin
                            state <= ST_SETTLE;
                            cnt   <= SETTLE_LD;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_SETTLE: begin
                        ser_rst <= 1'b0;
                        ser_d   <= IDLE_WORD;
                        link_up <= 1'b0;
                        if (cnt <= 16'd1) begin
                            state <= ST_TRAIN;
                            cnt   <= TRAIN_LD;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_TRAIN: begin
                        ser_rst <= 1'b0;
                        ser_d   <= TRAIN_PAT;
                        link_up <= 1'b0;
                        if (cnt <= 16'd1) begin
                            state <= ST_RUN;
                            cnt   <= 16'd0;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_RUN: begin
                        ser_rst <= 1'b0;
                        link_up <= 1'b1;
                        if (accept) begin
                            ser_d <= src_data;
                        end else begin
                            ser_d <= IDLE_WORD;
                        end
                        if (!src_valid && underrun_cnt != 16'hFFFF) begin
                            underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ser_rst <= 1'b1;
                        ser_d   <= IDLE_WORD;
                        link_up <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oser10_lane_ctrl.sv
// Bench for oser10_lane_ctrl: a default-parameter lane and a minimum-parameter lane share
// randomized stimulus and are compared every cycle against a timeline model of the bring-up sequence.
module tb_oser10_lane_ctrl;

    localparam logic [9:0] IDLE_W  = 10'h0AB;
    localparam logic [9:0] TRAIN_W = 10'h354;

    logic       clk = 1'b0;
    logic       srst, enable, pll_locked, src_valid;
    logic [9:0] src_data;

    logic        rdy0, rst0, link0, rdy1, rst1, link1;
    logic [9:0]  d0, d1;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  st0, st1;

    always #5 clk = ~clk;

    oser10_lane_ctrl dut0 (
        .clk_par(clk), .srst(srst), .enable(enable), .pll_locked(pll_locked),
        .src_valid(src_valid), .src_data(src_data), .src_ready(rdy0),
        .ser_rst(rst0), .ser_d(d0), .link_up(link0), .underrun_cnt(cnt0), .state_o(st0)
    );

    oser10_lane_ctrl #(.RST_CYCLES(1), .SETTLE_CYCLES(1), .TRAIN_WORDS(1)) dut1 (
        .clk_par(clk), .srst(srst), .enable(enable), .pll_locked(pll_locked),
        .src_valid(src_valid), .src_data(src_data), .src_ready(rdy1),
        .ser_rst(rst1), .ser_d(d1), .link_up(link1), .underrun_cnt(cnt1), .state_o(st1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: a lane is either idle or counting edges since the edge T that saw go.
    int R[2] = '{8, 1};
    int S[2] = '{2, 1};
    int W[2] = '{64, 1};
    int t_start[2] = '{-1, -1};
    int edge_n = 0;
    int exp_rst[2], exp_d[2], exp_link[2], exp_cnt[2];
    int pll_h1 = 0, pll_h2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int phase(input int i, input int e);
        int k;
        if (t_start[i] < 0) return 0;
        k = e - t_start[i];
        if (k <= R[i]) return 1;
        if (k <= R[i] + S[i]) return 2;
        if (k <= R[i] + S[i] + W[i]) return 3;
        return 4;
    endfunction

    task automatic model_edge();
        int e;
        int ph;
        bit go;
        e  = edge_n + 1;
        go = enable && (pll_h2 != 0);
        for (int i = 0; i < 2; i++) begin
            if (srst) begin
                t_start[i] = -1;
                exp_rst[i] = 1; exp_d[i] = IDLE_W; exp_link[i] = 0; exp_cnt[i] = 0;
            end else if (t_start[i] < 0) begin
                if (go) t_start[i] = e;
                exp_rst[i] = 1; exp_d[i] = IDLE_W; exp_link[i] = 0;
            end else if (!go) begin
                t_start[i] = -1;
                exp_rst[i] = 1; exp_d[i] = IDLE_W; exp_link[i] = 0;
            end else begin
                ph = phase(i, e);
                case (ph)
                    1: begin exp_rst[i] = 1; exp_d[i] = IDLE_W;  exp_link[i] = 0; end
                    2: begin exp_rst[i] = 0; exp_d[i] = IDLE_W;  exp_link[i] = 0; end
                    3: begin exp_rst[i] = 0; exp_d[i] = TRAIN_W; exp_link[i] = 0; end
                    default: begin
                        exp_rst[i]  = 0;
                        exp_link[i] = 1;
                        exp_d[i]    = src_valid ? int'(src_data) : int'(IDLE_W);
                        if (!src_valid && exp_cnt[i] < 65535) exp_cnt[i]++;
                    end
                endcase
            end
        end
        if (srst) begin
            pll_h1 = 0; pll_h2 = 0;
        end else begin
            pll_h2 = pll_h1; pll_h1 = pll_locked ? 1 : 0;
        end
        edge_n = e;
    endtask

    function automatic int exp_ready(input int i);
        return (phase(i, edge_n + 1) == 4 && enable && pll_h2 != 0) ? 1 : 0;
    endfunction

    // One cycle: drive at the falling edge, check ready, model the rising edge, check registers.
    task automatic step(input logic s, input logic en, input logic pl, input logic v, input logic [9:0] dat);
        srst = s; enable = en; pll_locked = pl; src_valid = v; src_data = dat;
        #1;
        if (edge_n > 0) begin
            check("d0.src_ready", 32'(rdy0), 32'(exp_ready(0)));
            check("d1.src_ready", 32'(rdy1), 32'(exp_ready(1)));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("d0.ser_rst",  32'(rst0),  32'(exp_rst[0]));
        check("d0.ser_d",    32'(d0),    32'(exp_d[0]));
        check("d0.link_up",  32'(link0), 32'(exp_link[0]));
        check("d0.underrun", 32'(cnt0),  32'(exp_cnt[0]));
        check("d0.state",    32'(st0),   32'(phase(0, edge_n + 1)));
        check("d1.ser_rst",  32'(rst1),  32'(exp_rst[1]));
        check("d1.ser_d",    32'(d1),    32'(exp_d[1]));
        check("d1.link_up",  32'(link1), 32'(exp_link[1]));
        check("d1.underrun", 32'(cnt1),  32'(exp_cnt[1]));
        check("d1.state",    32'(st1),   32'(phase(1, edge_n + 1)));
    endtask

    task automatic run_until(input int ph, input int budget);
        int n = 0;
        while (phase(0, edge_n + 1) != ph && n < budget) begin
            step(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom));
            n++;
        end
        check("wait_phase", 32'(phase(0, edge_n + 1)), 32'(ph));
    endtask

    initial begin
        srst = 1'b1; enable = 1'b1; pll_locked = 1'b1; src_valid = 1'b0; src_data = '0;

        // Reset and default bring-up.
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h0);
        check("rst.ser_rst", 32'(rst0), 32'd1);
        check("rst.ser_d",   32'(d0),   32'h0AB);
        check("rst.link_up", 32'(link0), 32'd0);
        check("rst.state",   32'(st0),  32'd0);
        run_until(4, 200);

        // Streaming 0x001..0x3FF with no gaps.
        for (int v = 1; v <= 10'h3FF; v++) step(1'b0, 1'b1, 1'b1, 1'b1, 10'(v));
        check("stream.last", 32'(d0), 32'h3FF);

        // Five-cycle underrun.
        for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 10'($urandom));
        check("underrun5", 32'(cnt0), 32'd5);

        // Lock loss mid-RUN, then mid-TRAIN at word 30.
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 1'b1, 10'($urandom));
        check("lockloss.state", 32'(st0), 32'd0);
        run_until(3, 200);
        for (int n = 0; n < 29; n++) step(1'b0, 1'b1, 1'b1, 1'b1, 10'($urandom));
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 1'b1, 10'($urandom));
        check("trainloss.rst", 32'(rst0), 32'd1);
        run_until(4, 200);

        // One-cycle enable glitch forces a full re-sequence.
        step(1'b0, 1'b0, 1'b1, 1'b1, 10'($urandom));
        check("glitch.state", 32'(st0), 32'd0);
        run_until(4, 200);

        // Randomized mix with occasional enable and lock drops.
        for (int n = 0; n < 600; n++)
            step(1'b0, 1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 79) != 0),
                 1'($urandom_range(0, 2) != 0), 10'($urandom));

        // Reset in RUN.
        run_until(4, 200);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h0);
        check("srst.underrun", 32'(cnt0), 32'd0);
        check("srst.link_up",  32'(link0), 32'd0);
        check("srst.ser_rst",  32'(rst0), 32'd1);

        // Saturation of the underrun counter.
        run_until(4, 200);
        for (int n = 0; n < 70000; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 10'h0);
        check("sat.d0", 32'(cnt0), 32'hFFFF);
        check("sat.d1", 32'(cnt1), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
